// File: rtl/approx_dot_acc.sv
// rtl/approx_dot_acc.sv - groups approximate-multiplier products into wide sums with count and sticky overflow
module approx_dot_acc #(
    parameter int LEN   = 16,
    parameter int ACC_W = 20,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_prod,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_ovf
);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic             accept;
    logic [ACC_W-1:0] base_acc;
    logic [CNT_W-1:0] base_cnt;
    logic             base_ovf;
    logic [ACC_W:0]   sum;
    logic [CNT_W-1:0] nxt_cnt;
    logic             nxt_ovf;
    logic             group_end;

    assign in_ready = (state == ST_ACC) || out_ready;
    assign accept   = in_valid && in_ready;

    // A term accepted during a HOLD handoff starts a fresh group, so it sums from zero.
    always_comb begin
        base_acc  = '0;
        base_cnt  = '0;
        base_ovf  = 1'b0;
        if (state == ST_ACC) begin
            base_acc = acc;
            base_cnt = cnt;
            base_ovf = ovf;
        end
        sum       = {1'b0, base_acc} + (ACC_W + 1)'(in_prod);
        nxt_cnt   = base_cnt + 1'b1;
        nxt_ovf   = base_ovf | sum[ACC_W];
        group_end = in_last || (nxt_cnt == CNT_W'(LEN));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_ACC;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_cnt   <= '0;
            out_ovf   <= 1'b0;
        end else if (accept) begin
            if (group_end) begin
                out_acc   <= sum[ACC_W-1:0];
                out_cnt   <= nxt_cnt;
                out_ovf   <= nxt_ovf;
                out_valid <= 1'b1;
                acc       <= '0;
                cnt       <= '0;
                ovf       <= 1'b0;
                state     <= ST_HOLD;
            end else begin
                acc       <= sum[ACC_W-1:0];
                cnt       <= nxt_cnt;
                ovf       <= nxt_ovf;
                out_valid <= 1'b0;
                state     <= ST_ACC;
            end
        end else if ((state == ST_HOLD) && out_ready) begin
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            state     <= ST_ACC;
        end
    end

endmodule

// File: tb/tb_approx_dot_acc.sv
// tb/tb_approx_dot_acc.sv - directed checks of approx_dot_acc across three parameter sets
module tb_approx_dot_acc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_prod = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;

    logic        a_in_ready, a_out_valid, a_out_ovf;
    logic [19:0] a_out_acc;
    logic [7:0]  a_out_cnt;
    logic        b_in_ready, b_out_valid, b_out_ovf;
    logic [15:0] b_out_acc;
    logic [7:0]  b_out_cnt;
    logic        c_in_ready, c_out_valid, c_out_ovf;
    logic [19:0] c_out_acc;
    logic [7:0]  c_out_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    approx_dot_acc #(.LEN(4), .ACC_W(20), .CNT_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_prod(in_prod), .in_last(in_last), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_acc(a_out_acc), .out_cnt(a_out_cnt), .out_ovf(a_out_ovf)
    );

    approx_dot_acc #(.LEN(4), .ACC_W(16), .CNT_W(8)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_prod(in_prod), .in_last(in_last), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_acc(b_out_acc), .out_cnt(b_out_cnt), .out_ovf(b_out_ovf)
    );

    approx_dot_acc #(.LEN(1), .ACC_W(20), .CNT_W(8)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_prod(in_prod), .in_last(in_last), .out_valid(c_out_valid),
        .out_ready(out_ready), .out_acc(c_out_acc), .out_cnt(c_out_cnt), .out_ovf(c_out_ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_prod   = '0;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] prod, input logic last);
        in_valid = 1'b1;
        in_prod  = prod;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic bubble();
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_valid", a_out_valid, 0);
        check("rst_acc", a_out_acc, 0);
        check("rst_cnt", a_out_cnt, 0);
        check("rst_ovf", a_out_ovf, 0);
        check("rst_ready", a_in_ready, 1);

        // Four-term group reaching LEN
        send(100, 0);
        send(200, 0);
        send(300, 0);
        check("t1_not_yet", a_out_valid, 0);
        send(400, 0);
        check("t1_valid", a_out_valid, 1);
        check("t1_acc", a_out_acc, 1000);
        check("t1_cnt", a_out_cnt, 4);
        check("t1_ovf", a_out_ovf, 0);
        bubble();
        check("t1_handoff", a_out_valid, 0);

        // in_last with bubbles
        do_reset();
        send(5, 0);
        bubble();
        bubble();
        check("t2_bubble_valid", a_out_valid, 0);
        send(7, 1);
        check("t2_valid", a_out_valid, 1);
        check("t2_acc", a_out_acc, 12);
        check("t2_cnt", a_out_cnt, 2);
        bubble();

        // Backpressure then handoff with a new first term
        do_reset();
        send(100, 0);
        send(200, 0);
        send(300, 0);
        send(400, 0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_prod   = 55;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t3_in_ready_low", a_in_ready, 0);
            @(posedge clk);
            #1;
            check("t3_hold_valid", a_out_valid, 1);
            check("t3_hold_acc", a_out_acc, 1000);
            check("t3_hold_cnt", a_out_cnt, 4);
        end
        out_ready = 1'b1;
        in_prod   = 9;
        #1;
        check("t3_in_ready_high", a_in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("t3_after_handoff", a_out_valid, 0);
        send(1, 1);
        check("t3_next_valid", a_out_valid, 1);
        check("t3_next_acc", a_out_acc, 10);
        check("t3_next_cnt", a_out_cnt, 2);
        bubble();

        // Overflow at ACC_W=16, then a handoff term starts the next group
        do_reset();
        send(16'hFFFF, 0);
        send(16'hFFFF, 0);
        send(1, 0);
        send(1, 0);
        check("t4_valid", b_out_valid, 1);
        check("t4_acc", b_out_acc, 0);
        check("t4_ovf", b_out_ovf, 1);
        check("t4_cnt", b_out_cnt, 4);
        send(2, 0);
        check("t4_handoff", b_out_valid, 0);
        send(3, 1);
        check("t4_next_valid", b_out_valid, 1);
        check("t4_next_acc", b_out_acc, 5);
        check("t4_next_ovf", b_out_ovf, 0);
        check("t4_next_cnt", b_out_cnt, 2);
        bubble();

        // Asynchronous reset mid-group discards the partial sum
        do_reset();
        send(50, 0);
        send(60, 0);
        check("t5_c_valid_pre", c_out_valid, 1);
        check("t5_c_acc_pre", c_out_acc, 60);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_c_valid_rst", c_out_valid, 0);
        check("t5_c_acc_rst", c_out_acc, 0);
        check("t5_c_cnt_rst", c_out_cnt, 0);
        check("t5_a_valid_rst", a_out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(1, 0);
        send(2, 0);
        send(3, 0);
        send(4, 1);
        check("t5_valid", a_out_valid, 1);
        check("t5_acc", a_out_acc, 10);
        check("t5_cnt", a_out_cnt, 4);
        bubble();

        // LEN=1 streaming
        do_reset();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_prod  = 16'(3 + i);
            in_last  = 1'b0;
            #1;
            check("t6_in_ready", c_in_ready, 1);
            @(posedge clk);
            #1;
            check("t6_valid", c_out_valid, 1);
            check("t6_acc", c_out_acc, 32'(3 + i));
            check("t6_cnt", c_out_cnt, 1);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("t6_drain", c_out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
